// File: rtl/seq_event_logger.sv
// Timestamps rising edges of a detector strobe into a first-word-fall-through event FIFO.
// Optional drop counter output enabled by defining SEQ_EVENT_DROP_CNT_EN.
module seq_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      det_in,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [TS_W-1:0]           m_ts,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      ovf,
    input  logic                      ovf_clr
`ifdef SEQ_EVENT_DROP_CNT_EN
    ,
    output logic [7:0]                drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [TS_W-1:0] ts_cnt_reg, ts_cnt_next;
    logic            det_q_reg;
    logic            armed_reg, armed_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]   level_reg, level_next;
    logic            ovf_reg, ovf_next;
    logic [TS_W-1:0] mem [DEPTH];

    logic det_event;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // armed_reg stays low after reset until det_in is seen low, so a strobe
    // already high at release cannot masquerade as a fresh rising edge.
    always_comb begin
        det_event   = det_in & ~det_q_reg & armed_reg;
        full        = (level_reg == FULL_LEVEL);
        pop         = m_valid & m_ready;
        push        = det_event & (~full | pop);
        drop        = det_event & full & ~pop;
        ts_cnt_next = ts_cnt_reg + 1'b1;
        armed_next  = armed_reg | ~det_in;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        ovf_next    = ovf_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt_reg <= '0;
            det_q_reg  <= 1'b0;
            armed_reg  <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            ts_cnt_reg <= ts_cnt_next;
            det_q_reg  <= det_in;
            armed_reg  <= armed_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Storage needs no reset: contents are only observed through m_ts while level > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= ts_cnt_reg;
        end
    end

    assign m_valid = (level_reg != '0);
    assign m_ts    = mem[rd_ptr_reg];
    assign level   = level_reg;
    assign ovf     = ovf_reg;

`ifdef SEQ_EVENT_DROP_CNT_EN
    logic [7:0] drop_cnt_reg, drop_cnt_next;

    // A drop in the same cycle as a clear restarts the count at one.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (drop) begin
            if (ovf_clr) begin
                drop_cnt_next = 8'd1;
            end else if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_next = drop_cnt_reg + 8'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_reg <= 8'd0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_seq_event_logger.sv
// Scoreboard bench for seq_event_logger: directed scenarios followed by randomized traffic.
module tb_seq_event_logger;

    localparam int TS_W  = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset;
    logic            det_in;
    logic            m_valid;
    logic            m_ready;
    logic [TS_W-1:0] m_ts;
    logic [LW-1:0]   level;
    logic            ovf;
    logic            ovf_clr;
`ifdef SEQ_EVENT_DROP_CNT_EN
    logic [7:0]      drop_cnt;
`endif

    seq_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .det_in  (det_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_ts    (m_ts),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`ifdef SEQ_EVENT_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: queue of stored timestamps and flags.
    int ref_q[$];
    int exp_q[$];
    int m_ts_cnt;
    bit m_prev;
    bit m_ovf;
    int m_drop;

    int n_vec;
    int n_miss;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        exp_q.delete();
        m_ts_cnt = 0;
        m_prev   = 1'b1;
        m_ovf    = 1'b0;
        m_drop   = 0;
    endtask

    task automatic model_step(input logic d, input logic r, input logic c);
        bit ev;
        bit pop;
        bit full;
        bit drop;
        ev     = d && !m_prev;
        m_prev = d;
        pop    = r && (ref_q.size() > 0);
        full   = (ref_q.size() == DEPTH);
        drop   = ev && full && !pop;
        if (pop) void'(ref_q.pop_front());
        if (ev && !drop) begin
            ref_q.push_back(m_ts_cnt);
            exp_q.push_back(m_ts_cnt);
        end
        if (drop) begin
            m_ovf  = 1'b1;
            m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (c) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        m_ts_cnt = (m_ts_cnt + 1) % (1 << TS_W);
    endtask

    task automatic cycle(input logic d, input logic r, input logic c);
        det_in  = d;
        m_ready = r;
        ovf_clr = c;
        @(posedge clk);
        model_step(d, r, c);
        #1;
    endtask

    task automatic pulse(input logic r, input logic c);
        cycle(1'b1, r, c);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        repeat (n) cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_ts(input int v);
        while (m_ts_cnt != v) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset(input logic d);
        det_in  = d;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        reset   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compares the head against the scoreboard and pops on handshake.
    always @(negedge clk) begin
        check("level", int'(level), ref_q.size());
        check("m_valid", int'(m_valid), int'(ref_q.size() != 0));
        check("ovf", int'(ovf), int'(m_ovf));
`ifdef SEQ_EVENT_DROP_CNT_EN
        check("drop_cnt", int'(drop_cnt), m_drop);
`endif
        if (m_valid && exp_q.size() > 0) begin
            check("m_ts", int'(m_ts), exp_q[0]);
            if (m_ready) void'(exp_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        reset   = 1'b0;
        det_in  = 1'b0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        apply_reset(1'b0);

        // Single pulse at ts 5, held without ready, then drained.
        wait_ts(5);
        pulse(1'b0, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        drain(2);

        // Long high strobe yields one entry.
        wait_ts(10);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        drain(2);

        // Five pulses four cycles apart into a four-deep FIFO: one drop.
        wait_ts(2);
        repeat (5) begin
            cycle(1'b1, 1'b0, 1'b0);
            repeat (3) cycle(1'b0, 1'b0, 1'b0);
        end
        drain(5);
        cycle(1'b0, 1'b0, 1'b1);

        // Full FIFO with event coincident with pop.
        repeat (4) pulse(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        drain(5);

        // Timestamp wrap: two events sixteen cycles apart.
        wait_ts(15);
        pulse(1'b0, 1'b0);
        repeat (14) cycle(1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        drain(3);

        // Drop coinciding with ovf_clr keeps ovf set; then clear it.
        repeat (4) pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        drain(5);

        // Mid-stream reset with det_in held high across release.
        repeat (3) pulse(1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        apply_reset(1'b1);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        drain(2);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset(logic'($urandom_range(0, 1)));
            end else begin
                cycle(logic'($urandom_range(0, 99) < 45),
                      logic'($urandom_range(0, 99) < 35),
                      logic'($urandom_range(0, 99) < 5));
            end
        end
        drain(DEPTH + 2);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seq_event_logger.md
SEQ_EVENT_LOGGER -- requirements
Module: seq_event_logger

Interface
REQ-001 The block SHALL have parameter TS_W, default 16, giving the timestamp width in bits (4..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the event FIFO depth in entries (power of 2, 2..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port det_in, input, 1, detect strobe from the upstream Moore sequence detector.
REQ-006 The block SHALL have port m_valid, output, 1, meaning the FIFO head holds an event.
REQ-007 The block SHALL have port m_ready, input, 1, meaning the consumer accepts the head.
REQ-008 The block SHALL have port m_ts, output, TS_W, giving the timestamp of the head event.
REQ-009 The block SHALL have port level, output, $clog2(DEPTH)+1, giving the current FIFO occupancy.
REQ-010 The block SHALL have port ovf, output, 1, a sticky flag meaning at least one event was dropped.
REQ-011 The block SHALL have port ovf_clr, input, 1, a synchronous clear for ovf.

Function
REQ-012 The block SHALL increment a free-running counter ts_cnt (TS_W bits) by 1 every cycle, wrapping from all-ones to 0.
REQ-013 The block SHALL register det_in into det_q each cycle; an event occurs in the cycle where det_in=1 and det_q=0 (rising edge).
- A det_in held high for several cycles yields exactly one event.
REQ-014 The block SHALL push ts_cnt, as sampled in the event cycle, into the FIFO on that cycle's clock edge when the FIFO is not full.
REQ-015 The FIFO SHALL be first-word-fall-through: m_valid=1 and m_ts=head exactly when level>0.
- An event first becomes visible on m_valid one cycle after its event cycle.
- There is no combinational det_in->m_valid path.
REQ-016 The block SHALL perform a pop when m_valid=1 and m_ready=1 at a clock edge; m_ready while m_valid=0 SHALL have no effect.
REQ-017 m_ts SHALL remain stable while m_valid=1 and m_ready=0.
REQ-018 When an event occurs with level=DEPTH and no pop that cycle, the block SHALL drop the event, set ovf=1, and leave FIFO contents unchanged.
REQ-019 When an event and a pop coincide at level=DEPTH, the block SHALL accept the event and leave level at DEPTH, with no drop and no ovf.
REQ-020 When an event and a pop coincide at 0<level<DEPTH, level SHALL be unchanged and ordering SHALL be preserved.
REQ-021 level SHALL update on the same edge as the push or pop and SHALL never exceed DEPTH.
REQ-022 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-023 ovf_clr=1 SHALL clear ovf on the next edge; if a drop occurs in the same cycle, ovf SHALL stay 1 (set wins).

Reset
REQ-024 While reset=0 the block SHALL asynchronously hold ts_cnt=0, det_q=0, both pointers=0, level=0, m_valid=0, and ovf=0.
- m_ts content is don't-care while m_valid=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued events immediately.
- After release, the first event is only possible on a 0->1 det_in transition seen after release.

Configuration
REQ-026 When macro SEQ_EVENT_DROP_CNT_EN is defined, the block SHALL add output port drop_cnt, 8 bits, counting dropped events.
- drop_cnt saturates at 255.
- drop_cnt resets to 0 and is cleared by ovf_clr with the same set-wins rule as REQ-023.
REQ-027 When SEQ_EVENT_DROP_CNT_EN is undefined, drop_cnt and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-028 Reset release, det_in pulse 1 cycle when ts_cnt=5, m_ready=0 -> next cycle m_valid=1, m_ts=5, level=1; holds indefinitely.
REQ-029 det_in high 4 consecutive cycles starting ts_cnt=10 -> exactly one entry, m_ts=10, level=1.
REQ-030 DEPTH=4, 5 single-cycle pulses at ts 2,6,10,14,18, m_ready=0 -> level=4, ovf=1, drop_cnt=1 (macro on); draining yields 2,6,10,14.
REQ-031 FIFO full, pulse coincident with m_ready=1 -> level stays 4, ovf=0, oldest popped, new ts appended last.
REQ-032 TS_W=4, pulse at ts_cnt=15 then at ts_cnt=16 cycles later -> queued m_ts values 15 then 15 (wrap verified).
REQ-033 Three queued events, reset=0 for 1 cycle mid-stream, det_in held high across release -> m_valid=0, level=0, no event until det_in falls and rises again.
